// File: rtl/inc_arbiter_if.sv
// Bundle between the button synchronizer / clock scaler and the increment arbiter.
// master drives pacing, button levels and lock; slave returns increment pulses and status.
// Widths follow DIGITS; grant_idx is at least one bit wide.
interface inc_arbiter_if #(
  parameter int DIGITS = 3
);
  localparam int GW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              tick;
  logic [DIGITS-1:0] req;
  logic              lock;
  logic [DIGITS-1:0] inc_out;
  logic [GW-1:0]     grant_idx;
  logic              busy;

  modport master (
    output tick,
    output req,
    output lock,
    input  inc_out,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  tick,
    input  req,
    input  lock,
    output inc_out,
    output grant_idx,
    output busy
  );
endinterface

// File: rtl/inc_arbiter.sv
// Round-robin increment arbiter with per-digit press / auto-repeat state machines.
// Latency: inc_out is registered, high one cycle after the granting tick; press to pending is one cycle.
// Backpressure: lock freezes grants and hold counters; events arriving on an already pending digit merge.
module inc_arbiter #(
  parameter int DIGITS       = 3,
  parameter int DELAY_TICKS  = 8,
  parameter int REPEAT_TICKS = 2
) (
  input logic          clk,
  input logic          reset,
  inc_arbiter_if.slave bus
);

  localparam int GW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXT = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
  localparam int CW   = (MAXT > 0) ? $clog2(MAXT + 1) : 1;

  localparam logic [CW-1:0] DELAY_C  = CW'(DELAY_TICKS);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);
  localparam logic [GW-1:0] LAST_IDX = GW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_FIRST  = 2'd1,
    HOLD_DELAY  = 2'd2,
    HOLD_REPEAT = 2'd3
  } state_t;

  // Per-digit state
  state_t            state     [DIGITS];
  state_t            state_nxt [DIGITS];
  logic [CW-1:0]     cnt       [DIGITS];
  logic [CW-1:0]     cnt_nxt   [DIGITS];
  logic [DIGITS-1:0] req_d;
  logic [DIGITS-1:0] pending;
  logic [DIGITS-1:0] pending_nxt;
  logic [DIGITS-1:0] press;

  // Arbitration
  logic              adv;
  logic [GW-1:0]     rr_ptr;
  logic              grant_vld;
  logic [GW-1:0]     grant_sel;
  logic [DIGITS-1:0] grant_oh;

  // Registered outputs
  logic [DIGITS-1:0] inc_q;
  logic [GW-1:0]     gidx_q;
  logic              busy_q;

  // A tick only advances arbitration and hold timing while not locked.
  assign adv   = bus.tick & ~bus.lock;
  // Edge detection keeps running under lock so presses are never lost.
  assign press = bus.req & ~req_d;

  // Round-robin pick over the registered pending vector: first search at/after rr_ptr, then wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = '0;
    grant_oh  = '0;
    if (adv) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!grant_vld && pending[i] && (GW'(i) >= rr_ptr)) begin
          grant_vld   = 1'b1;
          grant_sel   = GW'(i);
          grant_oh[i] = 1'b1;
        end
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (!grant_vld && pending[i]) begin
          grant_vld   = 1'b1;
          grant_sel   = GW'(i);
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  // Per-digit next state: the grant consumes the old flag first, so a same-cycle event set wins.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      pending_nxt[i] = pending[i] & ~grant_oh[i];

      case (state[i])
        IDLE: begin
          if (press[i]) begin
            pending_nxt[i] = 1'b1;
            cnt_nxt[i]     = '0;
            state_nxt[i]   = WAIT_FIRST;
          end
        end

        WAIT_FIRST: begin
          // A release here keeps the flag: a short tap still earns its one increment.
          if (press[i]) begin
            pending_nxt[i] = 1'b1;
          end
          if (grant_oh[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = bus.req[i] ? HOLD_DELAY : IDLE;
          end
        end

        HOLD_DELAY: begin
          if (!bus.req[i]) begin
            pending_nxt[i] = 1'b0;
            cnt_nxt[i]     = '0;
            state_nxt[i]   = IDLE;
          end else if (adv) begin
            if ((cnt[i] + 1'b1) == DELAY_C) begin
              pending_nxt[i] = 1'b1;
              cnt_nxt[i]     = '0;
              state_nxt[i]   = HOLD_REPEAT;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end

        HOLD_REPEAT: begin
          if (!bus.req[i]) begin
            pending_nxt[i] = 1'b0;
            cnt_nxt[i]     = '0;
            state_nxt[i]   = IDLE;
          end else if (adv) begin
            if ((cnt[i] + 1'b1) == REPEAT_C) begin
              pending_nxt[i] = 1'b1;
              cnt_nxt[i]     = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end

        default: begin
          pending_nxt[i] = 1'b0;
          cnt_nxt[i]     = '0;
          state_nxt[i]   = IDLE;
        end
      endcase
    end
  end

  // Per-digit state registers; reset discards any hold in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d   <= '0;
      pending <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      req_d   <= bus.req;
      pending <= pending_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Output pulse, last-grant index, busy flag and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q  <= '0;
      gidx_q <= '0;
      busy_q <= 1'b0;
      rr_ptr <= '0;
    end else begin
      inc_q  <= grant_oh;
      busy_q <= |pending_nxt;
      if (grant_vld) begin
        gidx_q <= grant_sel;
        rr_ptr <= (grant_sel == LAST_IDX) ? '0 : (grant_sel + 1'b1);
      end
    end
  end

  assign bus.inc_out   = inc_q;
  assign bus.grant_idx = gidx_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: directed stimulus with a pulse scoreboard.
// Stimulus pushes expected pulses (cycle, one-hot, index); a negedge monitor pops and compares.
// Ticks are issued every third cycle; DIGITS=3, DELAY_TICKS=4, REPEAT_TICKS=2.
module tb_inc_arbiter;

  localparam int DIGITS = 3;
  localparam int DLY    = 4;
  localparam int RPT    = 2;

  logic clk = 1'b0;
  logic reset;

  inc_arbiter_if #(.DIGITS(DIGITS)) bus ();

  inc_arbiter #(
    .DIGITS      (DIGITS),
    .DELAY_TICKS (DLY),
    .REPEAT_TICKS(RPT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] oh;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [19:0] hold_mask;
  logic [7:0]  rst_mask;

  // Cycle counter used to timestamp expected and observed pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expectation, and no expectation may lapse.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (bus.inc_out != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got inc_out=%b at cycle %0d, required none", bus.inc_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_cycle", cyc, mon_e.cyc);
          check("pulse_inc_out", int'(bus.inc_out), int'(mon_e.oh));
          check("pulse_grant_idx", int'(bus.grant_idx), int'(mon_e.idx));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_pulse", 0, int'(mon_e.oh));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick cycle followed by two quiet cycles; returns after the pulse has been checked.
  task automatic tk(input logic [2:0] oh, input logic [1:0] idx);
    exp_t e;
    @(negedge clk);
    bus.tick = 1'b1;
    if (oh != 3'b000) begin
      e.cyc = cyc + 1;
      e.oh  = oh;
      e.idx = idx;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.req  = 3'b000;
    bus.lock = 1'b0;
    reset    = 1'b0;
    hold_mask = 20'b1010_1010_1010_1010_0001;
    rst_mask  = 8'b1010_0001;
    #1 reset = 1'b1;
    idle(3);
    check("reset_inc_out", int'(bus.inc_out), 0);
    check("reset_grant_idx", int'(bus.grant_idx), 0);
    check("reset_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Round-robin: three simultaneous taps granted 0, 1, 2.
    bus.req = 3'b111;
    idle(2);
    bus.req = 3'b000;
    check("rr_busy_before", int'(bus.busy), 1);
    tk(3'b001, 2'd0);
    tk(3'b010, 2'd1);
    tk(3'b100, 2'd2);
    tk(3'b000, 2'd0);
    check("rr_busy_after", int'(bus.busy), 0);

    // Pointer wrapped to 0: taps on 0 and 2 must grant 0 first.
    bus.req = 3'b101;
    idle(2);
    bus.req = 3'b000;
    tk(3'b001, 2'd0);
    tk(3'b100, 2'd2);

    // Single tap on digit 1 for three cycles.
    bus.req = 3'b010;
    idle(3);
    bus.req = 3'b000;
    check("tap_busy_before", int'(bus.busy), 1);
    check("tap_no_early_pulse", int'(bus.inc_out), 0);
    tk(3'b010, 2'd1);
    check("tap_busy_after", int'(bus.busy), 0);
    tk(3'b000, 2'd0);
    tk(3'b000, 2'd0);

    // Hold digit 0 for 20 ticks: pulses at 0,5,7,...,19; silence after release.
    bus.req = 3'b001;
    idle(2);
    for (int k = 0; k < 20; k++) begin
      tk(hold_mask[k] ? 3'b001 : 3'b000, 2'd0);
    end
    bus.req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tk(3'b000, 2'd0);
    end
    check("hold_busy_after", int'(bus.busy), 0);

    // Lock: tap on digit 2 is remembered but not granted until unlock.
    bus.lock = 1'b1;
    bus.req  = 3'b100;
    idle(2);
    bus.req  = 3'b000;
    for (int k = 0; k < 5; k++) begin
      tk(3'b000, 2'd0);
    end
    check("lock_busy", int'(bus.busy), 1);
    check("lock_grant_idx_held", int'(bus.grant_idx), 0);
    bus.lock = 1'b0;
    tk(3'b100, 2'd2);
    check("unlock_busy", int'(bus.busy), 0);
    tk(3'b000, 2'd0);
    check("grant_idx_held", int'(bus.grant_idx), 2);

    // Press edge in the same cycle as a tick: granted only on the following tick.
    @(negedge clk);
    bus.req  = 3'b010;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("sim_busy", int'(bus.busy), 1);
    @(negedge clk);
    bus.req = 3'b000;
    tk(3'b010, 2'd1);
    tk(3'b000, 2'd0);

    // Reset mid-hold, then the still-held button restarts as a fresh press.
    bus.req = 3'b001;
    idle(2);
    for (int k = 0; k < 5; k++) begin
      tk((k == 0) ? 3'b001 : 3'b000, 2'd0);
    end
    begin
      exp_t e;
      @(negedge clk);
      bus.tick = 1'b1;
      e.cyc = cyc + 1;
      e.oh  = 3'b001;
      e.idx = 2'd0;
      exp_q.push_back(e);
      @(negedge clk);
      bus.tick = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("async_reset_inc_out", int'(bus.inc_out), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    idle(2);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tk(rst_mask[k] ? 3'b001 : 3'b000, 2'd0);
    end
    bus.req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tk(3'b000, 2'd0);
    end

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
